// File: rtl/sdram_port_arbiter.sv
// Three-port SDRAM arbiter: video fixed priority with burst cap,
// CPU and ioctl round-robin, one outstanding transaction with timeout.
module sdram_port_arbiter #(
  parameter int ADDR_W        = 24,
  parameter int MAX_VID_BURST = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic                clk_chipset,
  input  logic                RESET_N,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [47:0]         wdata,
  input  logic [5:0]          be,
  output logic [2:0]          ack,
  output logic [15:0]         rdata,
  output logic [1:0]          grant_id,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_wdata,
  output logic [1:0]          mem_be,
  input  logic                mem_ack,
  input  logic [15:0]         mem_rdata,
  output logic                timeout_err
);

  localparam int VW = $clog2(MAX_VID_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [VW-1:0] VMAX  = VW'(MAX_VID_BURST);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [VW-1:0]       vid_cnt_q, vid_cnt_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [2:0]          ack_q, ack_d;
  logic [15:0]         rdata_q, rdata_d;
  logic [1:0]          grant_q, grant_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_be_q, mem_be_d;
  logic                tmo_err_q, tmo_err_d;

  logic       vid_win;
  logic       take2;
  logic [1:0] win;

  // Video yields only once its burst is spent and someone else waits.
  always_comb begin
    vid_win = req[0] && !(vid_cnt_q == VMAX && (req[1] | req[2]));
    take2   = (rr_ptr_q == 2'd2) ? req[2] : !req[1];
    win     = 2'd1;
    unique case (1'b1)
      vid_win:           win = 2'd0;
      !vid_win && take2: win = 2'd2;
      default:           win = 2'd1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    vid_cnt_d   = vid_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    ack_d       = 3'b000;
    rdata_d     = rdata_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    tmo_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d     = S_WAIT;
          grant_d     = win;
          mem_req_d   = 1'b1;
          tmo_cnt_d   = '0;
          mem_we_d    = we[win];
          mem_addr_d  = addr[win*ADDR_W +: ADDR_W];
          mem_wdata_d = wdata[win*16 +: 16];
          mem_be_d    = be[win*2 +: 2];
          if (win == 2'd0) begin
            if (vid_cnt_q != VMAX) vid_cnt_d = vid_cnt_q + 1'b1;
          end else begin
            vid_cnt_d = '0;
            rr_ptr_d  = (win == 2'd1) ? 2'd2 : 2'd1;
          end
        end
      end
      S_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (mem_ack || tmo_cnt_q == TLAST) begin
          state_d   = S_IDLE;
          ack_d     = 3'b001 << grant_q;
          rdata_d   = mem_ack ? mem_rdata : 16'hFFFF;
          tmo_err_d = !mem_ack;
          mem_req_d = 1'b0;
          grant_d   = 2'd3;
          tmo_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_chipset or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 2'd1;
      vid_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      ack_q       <= 3'b000;
      rdata_q     <= 16'h0000;
      grant_q     <= 2'd3;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 16'h0000;
      mem_be_q    <= 2'b00;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      vid_cnt_q   <= vid_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign grant_id    = grant_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: transaction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_sdram_port_arbiter;

  localparam int AW   = 24;
  localparam int MAXB = 4;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          RESET_N;
  logic [2:0]    req;
  logic [2:0]    we;
  logic [3*AW-1:0] addr;
  logic [47:0]   wdata;
  logic [5:0]    be;
  logic [2:0]    ack;
  logic [15:0]   rdata;
  logic [1:0]    grant_id;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_be;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic          timeout_err;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W(AW), .MAX_VID_BURST(MAXB), .TIMEOUT(TMO)
  ) dut (
    .clk_chipset(clk), .RESET_N(RESET_N),
    .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .rdata(rdata), .grant_id(grant_id),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  // requesters: port n requests while want[n] exceeds acks seen
  int            want[3] = '{0, 0, 0};
  int            done[3] = '{0, 0, 0};
  logic          p_we[3];
  logic [AW-1:0] p_addr[3];
  logic [15:0]   p_wdata[3];
  logic [1:0]    p_be[3];

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      req[n]            = want[n] > done[n];
      we[n]             = p_we[n];
      addr[n*AW +: AW]  = p_addr[n];
      wdata[n*16 +: 16] = p_wdata[n];
      be[n*2 +: 2]      = p_be[n];
    end
  end

  always @(negedge clk)
    for (int n = 0; n < 3; n++) if (ack[n]) done[n]++;

  // memory controller stand-in
  logic        mem_en = 1'b1;
  int          r_delay = 3;
  int          r_cnt = 0;
  logic [15:0] rd_val = 16'h0;
  logic        hit = 1'b0;
  logic        stray = 1'b0;

  assign mem_ack = hit | stray;

  always @(negedge clk) begin
    if (!RESET_N || !mem_req) begin
      r_cnt = 0;
      hit = 1'b0;
    end else if (mem_en) begin
      r_cnt++;
      hit = (r_cnt == r_delay);
    end else begin
      hit = 1'b0;
    end
    mem_rdata = rd_val;
  end

  // reference model
  bit          m_busy;
  int          m_owner, m_waited, m_vid, m_last;
  logic [2:0]  e_ack;
  logic [15:0] e_rdata, e_wdata;
  logic [1:0]  e_grant, e_be;
  logic        e_mreq, e_we, e_terr;
  logic [AW-1:0] e_addr;

  task automatic model_reset();
    m_busy = 0; m_owner = 3; m_waited = 0; m_vid = 0; m_last = 2;
    e_ack = 0; e_rdata = 0; e_grant = 3; e_mreq = 0; e_we = 0;
    e_addr = 0; e_wdata = 0; e_be = 0; e_terr = 0;
  endtask

  task automatic model_finish(input logic [15:0] d, input logic err);
    e_ack = 3'(1 << m_owner);
    e_rdata = d;
    e_terr = err;
    e_mreq = 0;
    e_grant = 3;
    m_busy = 0;
  endtask

  task automatic model_step();
    int w, pref;
    e_ack = 0;
    e_terr = 0;
    if (!m_busy) begin
      if (req != 3'b000) begin
        if (req[0] && !(m_vid >= MAXB && (req[1] || req[2]))) w = 0;
        else begin
          pref = (m_last == 1) ? 2 : 1;
          w = req[pref] ? pref : 3 - pref;
        end
        if (w == 0) m_vid = (m_vid < MAXB) ? m_vid + 1 : MAXB;
        else begin
          m_vid = 0;
          m_last = w;
        end
        m_busy = 1; m_owner = w; m_waited = 0;
        e_grant = 2'(w); e_mreq = 1;
        e_we = p_we[w]; e_addr = p_addr[w];
        e_wdata = p_wdata[w]; e_be = p_be[w];
      end
    end else begin
      m_waited++;
      if (mem_ack) model_finish(mem_rdata, 1'b0);
      else if (m_waited == TMO) model_finish(16'hFFFF, 1'b1);
    end
  endtask

  always @(posedge clk) begin
    if (!RESET_N) model_reset();
    else model_step();
    #1;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("rdata", 32'(rdata), 32'(e_rdata));
    chk("grant_id", 32'(grant_id), 32'(e_grant));
    chk("mem_req", 32'(mem_req), 32'(e_mreq));
    chk("timeout_err", 32'(timeout_err), 32'(e_terr));
    if (e_mreq) begin
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("mem_be", 32'(mem_be), 32'(e_be));
    end
  end

  // grant_id change log and activity counters
  int         gq[$];
  logic [1:0] last_g = 2'd3;
  int         mreq_cyc = 0;

  always @(posedge clk) begin
    #2;
    if (grant_id != last_g) begin
      gq.push_back(int'(grant_id));
      last_g = grant_id;
    end
    if (mem_req) mreq_cyc++;
  end

  task automatic pulse_reset();
    @(negedge clk); RESET_N = 1'b0;
    @(negedge clk); RESET_N = 1'b1;
  endtask

  task automatic wait_ack(input int p, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = ack[p];
    end
    chk($sformatf("ack%0d_seen", p), 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (want[0] == done[0]) && (want[1] == done[1]) &&
           (want[2] == done[2]) && !mem_req;
    end
    chk("all_done", 32'(ok), 32'd1);
  endtask

  task automatic chk_seq(input string nm, input int base,
                         input int exp[$], input bit skip3);
    int act[$];
    for (int i = base; i < gq.size(); i++)
      if (!(skip3 && gq[i] == 3)) act.push_back(gq[i]);
    chk({nm, "_len"}, 32'(act.size() >= exp.size()), 32'd1);
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), 32'(act[i]), 32'(exp[i]));
  endtask

  initial begin
    int base, s;
    int e3[$], e4[$], e5[$];
    e3 = '{0, 3, 1, 3, 2, 3};
    e4 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    e5 = '{1, 2, 1, 2};
    RESET_N = 1'b0;
    for (int n = 0; n < 3; n++) begin
      p_we[n] = 0; p_addr[n] = 24'(n * 24'h100); p_wdata[n] = 16'(n);
      p_be[n] = 2'b11;
    end
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant_id), 32'd3);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    RESET_N = 1'b1;

    // single read on port 1
    p_addr[1] = 24'h000123; p_we[1] = 0; rd_val = 16'hBEEF; r_delay = 3;
    @(negedge clk);
    s = mreq_cyc;
    want[1]++;
    wait_ack(1, 20);
    chk("t1_ack", 32'(ack), 32'b010);
    chk("t1_rdata", 32'(rdata), 32'hBEEF);
    chk("t1_addr", 32'(mem_addr), 32'h000123);
    chk("t1_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("t1_ack_1cyc", 32'(ack), 32'd0);
    chk("t1_mreq_cycles", 32'(mreq_cyc - s), 32'd3);

    // write on port 2
    p_we[2] = 1; p_wdata[2] = 16'h55AA; p_be[2] = 2'b01;
    p_addr[2] = 24'h000456; r_delay = 2;
    want[2]++;
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    chk("t2_we", 32'(mem_we), 32'd1);
    chk("t2_wdata", 32'(mem_wdata), 32'h55AA);
    chk("t2_be", 32'(mem_be), 32'b01);
    wait_ack(2, 20);
    chk("t2_ack", 32'(ack), 32'b100);
    p_we[2] = 0; p_be[2] = 2'b11;

    // all three from reset
    pulse_reset();
    base = gq.size();
    want[0]++; want[1]++; want[2]++;
    wait_done(100);
    chk_seq("t3_seq", base, e3, 0);

    // video burst cap against port 1
    r_delay = 1;
    base = gq.size();
    want[0] += 8; want[1] += 2;
    wait_done(200);
    chk_seq("t4_seq", base, e4, 1);

    // port 1/2 round robin
    pulse_reset();
    r_delay = 2;
    base = gq.size();
    want[1] += 2; want[2] += 2;
    wait_done(100);
    chk_seq("t5_seq", base, e5, 1);

    // timeout
    mem_en = 1'b0;
    s = mreq_cyc;
    want[1]++;
    wait_ack(1, 200);
    chk("t6_terr", 32'(timeout_err), 32'd1);
    chk("t6_ack", 32'(ack), 32'b010);
    chk("t6_rdata", 32'(rdata), 32'hFFFF);
    chk("t6_wait_cycles", 32'(mreq_cyc - s), 32'd64);
    @(negedge clk);
    chk("t6_terr_1cyc", 32'(timeout_err), 32'd0);
    mem_en = 1'b1;

    // mem_ack coincident with the last allowed cycle
    r_delay = 64; rd_val = 16'h1234;
    want[2]++;
    wait_ack(2, 200);
    chk("tc_no_err", 32'(timeout_err), 32'd0);
    chk("tc_rdata", 32'(rdata), 32'h1234);

    // stray mem_ack while idle
    @(negedge clk); #2 stray = 1'b1;
    @(negedge clk); #2 stray = 1'b0;
    @(negedge clk);
    chk("stray_grant", 32'(grant_id), 32'd3);
    chk("stray_rdata", 32'(rdata), 32'h1234);

    // reset during WAIT
    mem_en = 1'b0; r_delay = 2;
    want[1]++;
    repeat (5) @(negedge clk);
    RESET_N = 1'b0;
    #1;
    chk("t7_mreq", 32'(mem_req), 32'd0);
    chk("t7_grant", 32'(grant_id), 32'd3);
    chk("t7_ack", 32'(ack), 32'd0);
    @(negedge clk);
    RESET_N = 1'b1;
    mem_en = 1'b1;
    wait_ack(1, 20);
    chk("t7_regrant_ack", 32'(ack), 32'b010);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
